// File: rtl/alu_pkg.sv
// Shared widths and FSM state encoding for the ALU command master.
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 32;
  localparam int RES_W  = 33;
  localparam int CMD_W  = 2 * DATA_W + OP_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: registered occupancy count, combinational head read.
// A push and a pop in the same cycle both take effect, even when full.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && (!full || rd_en);
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_master.sv
// Queues ALU commands and issues them one at a time over a four-phase
// en/ack handshake, with a per-command timeout and a valid/ready response.
module alu_cmd_master
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_en,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   to_cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [CMD_W-1:0]   head;
  logic [DATA_W-1:0]  head_a;
  logic [DATA_W-1:0]  head_b;
  logic [OP_W-1:0]    head_op;

  // A push while full is never a handshake; the source keeps offering.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign {head_a, head_b, head_op} = head;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({cmd_a, cmd_b, cmd_op}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Issue FSM: one command in flight; ALU outputs and response fields registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      alu_en      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a      <= head_a;
            alu_b      <= head_b;
            alu_opcode <= head_op;
            alu_en     <= 1'b1;
            to_cnt     <= '0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack on the final allowed cycle still counts as a completion.
          if (alu_ack) begin
            rsp_result  <= alu_result;
            rsp_op      <= alu_opcode;
            rsp_timeout <= 1'b0;
            alu_en      <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (to_cnt == TO_LAST) begin
            rsp_result  <= '0;
            rsp_op      <= alu_opcode;
            rsp_timeout <= 1'b1;
            alu_en      <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Four-phase: the ALU must drop ack before the next request.
          if (!alu_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master with a behavioural ALU model.
module tb_alu_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_opcode;
  logic        alu_en;
  logic [32:0] alu_result;
  logic        alu_ack;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [32:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // ALU model controls
  bit ack_on;
  int ack_dly;
  int hold_cyc;
  int mcnt;
  int mhold;
  int en_bad;
  logic prev_en;

  typedef struct packed {
    logic [32:0] res;
    logic [2:0]  op;
    logic        to;
  } rsp_t;
  rsp_t rsp_q[$];

  always #5 clk = ~clk;

  alu_cmd_master #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_en      (alu_en),
    .alu_result  (alu_result),
    .alu_ack     (alu_ack),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_op      (rsp_op),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd1:    alu_f = {1'b0, a} + {1'b0, b};
      3'd2:    alu_f = {1'b0, a} - {1'b0, b};
      default: alu_f = {1'b0, a ^ b};
    endcase
  endfunction

  // Response monitor and ALU model, both on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      alu_ack    = 1'b0;
      alu_result = '0;
      mcnt       = 0;
      mhold      = 0;
      prev_en    = 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_result, rsp_op, rsp_timeout});
      if (alu_en && !prev_en && alu_ack) en_bad++;
      prev_en = alu_en;
      if (alu_en && !alu_ack) begin
        mcnt++;
        if (ack_on && mcnt >= ack_dly) begin
          alu_ack    = 1'b1;
          alu_result = alu_f(alu_a, alu_b, alu_opcode);
          mhold      = hold_cyc;
          mcnt       = 0;
        end
      end else if (!alu_en && alu_ack) begin
        if (mhold == 0) alu_ack = 1'b0;
        else mhold--;
      end else if (!alu_en) begin
        mcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("send_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chk("idle", busy, 0);
  endtask

  task automatic expect_rsp(input string tag, input logic [32:0] res, input logic [2:0] op,
                            input logic to);
    int n;
    rsp_t r;
    n = 0;
    while (rsp_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_present"}, (rsp_q.size() != 0), 1);
    if (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      chk({tag, "_result"}, r.res, res);
      chk({tag, "_op"}, r.op, op);
      chk({tag, "_timeout"}, r.to, to);
    end
  endtask

  logic [31:0] bp_a  [6] = '{32'd100, 32'd50, 32'hFFFF_FFFF, 32'd9, 32'd5, 32'd1};
  logic [31:0] bp_b  [6] = '{32'd7,   32'd8,  32'd1,         32'd3, 32'd6, 32'd1};
  logic [2:0]  bp_op [6] = '{3'd1,    3'd2,   3'd1,          3'd3,  3'd2,  3'd1};
  logic [32:0] bp_exp[5] = '{33'd107, 33'd42, 33'h1_0000_0000, 33'd10, 33'h1_FFFF_FFFF};

  initial begin
    int acc;
    int sent;
    int cyc;
    int en_cyc;
    bit saw_full;

    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    rsp_ready = 1'b1;
    ack_on = 1'b1;
    ack_dly = 3;
    hold_cyc = 0;
    en_bad = 0;

    // Reset state
    tick();
    tick();
    chk("rst_alu_en", alu_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_op", rsp_op, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);

    // Single op, accept-to-enable latency
    cmd_valid = 1'b1;
    cmd_a = 32'd13;
    cmd_b = 32'd5;
    cmd_op = 3'd1;
    chk("t1_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t1_en_early", alu_en, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_en", alu_en, 1);
    chk("t1_alu_a", alu_a, 13);
    chk("t1_alu_b", alu_b, 5);
    chk("t1_alu_op", alu_opcode, 1);
    expect_rsp("t1", 33'd18, 3'd1, 1'b0);

    // Backpressure: 1 in flight + 4 queued, sixth refused
    idle_wait();
    rsp_ready = 1'b0;
    ack_dly = 1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_a = bp_a[i];
      cmd_b = bp_b[i];
      cmd_op = bp_op[i];
      if (cmd_ready) acc++;
      if (i == 5) chk("bp_ready6", cmd_ready, 0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_none_yet", rsp_q.size(), 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_rsp($sformatf("bp%0d", i), bp_exp[i], bp_op[i], 1'b0);

    // Streaming into a full FIFO: order preserved, nothing lost or duplicated
    idle_wait();
    ack_dly = 3;
    sent = 0;
    cyc = 0;
    saw_full = 1'b0;
    while (sent < 12 && cyc < 300) begin
      cmd_valid = 1'b1;
      cmd_a = 32'(1000 + sent);
      cmd_b = 32'(sent);
      cmd_op = 3'd1;
      if (cmd_ready) sent++;
      else saw_full = 1'b1;
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    chk("ff_sent", sent, 12);
    chk("ff_saw_full", saw_full, 1);
    for (int i = 0; i < 12; i++) expect_rsp($sformatf("ff%0d", i), 33'(1000 + 2 * i), 3'd1, 1'b0);
    idle_wait();
    chk("ff_no_extra", rsp_q.size(), 0);

    // Timeout: en held exactly 16 cycles, then a normal command
    ack_on = 1'b0;
    send(32'h55, 32'h1, 3'd2);
    en_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (alu_en) en_cyc++;
      tick();
    end
    chk("to_en_cycles", en_cyc, 16);
    expect_rsp("to", 33'd0, 3'd2, 1'b1);
    ack_on = 1'b1;
    ack_dly = 2;
    send(32'd7, 32'd9, 3'd1);
    expect_rsp("to_next", 33'd16, 3'd1, 1'b0);

    // Held ack: next request waits for ack to fall
    idle_wait();
    ack_dly = 1;
    hold_cyc = 5;
    en_bad = 0;
    send(32'd3, 32'd4, 3'd1);
    send(32'd10, 32'd4, 3'd2);
    expect_rsp("ha0", 33'd7, 3'd1, 1'b0);
    expect_rsp("ha1", 33'd6, 3'd2, 1'b0);
    idle_wait();
    chk("ha_en_while_ack", en_bad, 0);
    hold_cyc = 0;

    // Reset mid-request with 3 queued
    ack_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 32'(i + 1);
      cmd_b = 32'd2;
      cmd_op = 3'd1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("mr_pre_en", alu_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_alu_en", alu_en, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_alu_a", alu_a, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    tick();
    rst = 1'b0;
    ack_on = 1'b1;
    ack_dly = 1;
    en_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      if (alu_en) en_cyc++;
      tick();
    end
    chk("mr_no_issue", en_cyc, 0);
    chk("mr_no_rsp", rsp_q.size(), 0);
    chk("mr_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 16, max cycles alu_en waits for alu_ack.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  FIFO not full.
REQ-008 cmd_a, cmd_b  input  32 each  operands.
REQ-009 cmd_op  input  3  ALU opcode.
REQ-010 alu_a, alu_b  output  32 each  operands driven to ALU.
REQ-011 alu_opcode  output  3  opcode driven to ALU.
REQ-012 alu_en  output  1  request to ALU.
REQ-013 alu_result  input  33  ALU result, carry in bit 32.
REQ-014 alu_ack  input  1  ALU completion.
REQ-015 rsp_valid / rsp_ready  output / input  1 each  response handshake.
REQ-016 rsp_result  output  33; rsp_op  output  3; rsp_timeout  output  1.
REQ-017 busy  output  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-018 Command accepted on any clk edge with cmd_valid && cmd_ready; written into FIFO; cmd_ready = !full, combinational from registered count.
REQ-019 FSM states SHALL be IDLE, REQ, RESP, DRAIN.
REQ-020 IDLE: FIFO non-empty -> pop head, register alu_a/alu_b/alu_opcode, alu_en=1, go REQ; accept to alu_en high = 2 cycles when idle and FIFO empty.
REQ-021 REQ: alu_en held high, operands stable; alu_ack==1 sampled -> capture alu_result into rsp_result, rsp_timeout=0, alu_en=0, rsp_valid=1, go RESP.
REQ-022 REQ: timeout counter increments each REQ cycle; reaching TIMEOUT without ack -> rsp_result=0, rsp_timeout=1, alu_en=0, rsp_valid=1, go RESP.
REQ-023 RESP: hold rsp_* stable until rsp_ready; on handshake rsp_valid=0, go DRAIN.
REQ-024 DRAIN: wait alu_ack==0 (four-phase), then IDLE; alu_ack already low -> IDLE next cycle.
REQ-025 rsp_op SHALL equal opcode of the command that produced the response.
REQ-026 FIFO push and pop in same cycle SHALL both succeed, count unchanged, including when full (cmd_ready stays low; push at full is not a handshake).
REQ-027 Pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-028 Commands SHALL issue strictly in acceptance order, at most one outstanding.
REQ-029 alu_ack outside REQ/DRAIN SHALL be ignored.

Reset
REQ-030 rst SHALL immediately force: state IDLE, FIFO empty, counter 0, alu_en=0, alu_a=alu_b=0, alu_opcode=0, rsp_valid=0, rsp_result=0, rsp_op=0, rsp_timeout=0, cmd_ready=1 after release, busy=0.
REQ-031 Reset mid-REQ drops in-flight and queued commands; no response produced.

Structure
REQ-032 Shared package alu_pkg SHALL hold opcode width (3), data width (32), result width (33), FSM state enum.
REQ-033 FIFO SHALL be sub-module alu_cmd_fifo (width 67, DEPTH deep); FSM and timeout counter in top.

Verification
REQ-034 Single op: a=13,b=5,op=001, model ALU acks after 3 cycles with 18 -> alu_en high 2 cycles after accept, rsp_result=18, rsp_op=001, rsp_timeout=0.
REQ-035 Backpressure: rsp_ready=0, push 6 commands, ALU acks promptly -> 5 accepted (1 in flight + 4 queued), cmd_ready low on 6th; release rsp_ready -> 5 responses in order.
REQ-036 Timeout: ALU never acks -> alu_en high exactly 16 cycles, then rsp_timeout=1, rsp_result=0; next command proceeds normally.
REQ-037 Full FIFO simultaneous push/pop: count stays 4, no command lost or duplicated.
REQ-038 Reset asserted while alu_en=1 with 3 queued -> alu_en=0 and rsp_valid=0 same cycle, busy=0, no responses after release.
REQ-039 Held ack: ALU keeps ack high 5 cycles after en drops -> next alu_en not asserted until ack low.
